// File: rtl/shift_reg_chain.sv
`default_nettype none
// ============================================================================
// Module   : shift_reg_chain
// Brief    : Serial driver for N daisy-chained 74HC595 shift registers.
// Revision : 1.0
// ============================================================================
module shift_reg_chain #(
  parameter int N_CHIPS   = 2,
  parameter int CLK_DIV   = 2,
  parameter int LSB_FIRST = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [8*N_CHIPS-1:0] i_Data,
  input  logic                 i_Enable,
  input  logic                 i_Clear,
  output logic                 o_Ready,
  output logic                 o_Done,
  output logic                 o_SER,
  output logic                 o_SRCLK,
  output logic                 o_RCLK,
  output logic                 o_SRCLR_n,
  output logic                 o_OE_n
);

  localparam int c_W     = 8 * N_CHIPS;
  localparam int c_BIT_W = (c_W > 1) ? $clog2(c_W) : 1;
  localparam int c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(c_W - 1);
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);

  localparam logic [2:0] c_S_IDLE      = 3'd0;
  localparam logic [2:0] c_S_SHIFT_LO  = 3'd1;
  localparam logic [2:0] c_S_SHIFT_HI  = 3'd2;
  localparam logic [2:0] c_S_LATCH     = 3'd3;
  localparam logic [2:0] c_S_CLR       = 3'd4;
  localparam logic [2:0] c_S_CLR_LATCH = 3'd5;

  logic [2:0]         r_state;
  logic [c_W-1:0]     r_buf;
  logic [c_BIT_W-1:0] r_bit_cnt;
  logic [c_DIV_W-1:0] r_div_cnt;
  logic               r_ready;
  logic               r_done;
  logic               r_ser;
  logic               r_srclk;
  logic               r_rclk;
  logic               r_srclr_n;
  logic               r_oe_n;

  logic [2:0]         w_state_nxt;
  logic [c_W-1:0]     w_buf_nxt;
  logic [c_W-1:0]     w_buf_shift;
  logic [c_BIT_W-1:0] w_bit_cnt_nxt;
  logic [c_DIV_W-1:0] w_div_cnt_nxt;
  logic               w_div_last;
  logic               w_ser_bit;
  logic               w_latched;
  logic               w_done_nxt;
  logic               w_ready_nxt;
  logic               w_ser_nxt;
  logic               w_srclk_nxt;
  logic               w_rclk_nxt;
  logic               w_srclr_n_nxt;
  logic               w_oe_n_nxt;

  assign w_div_last = (r_div_cnt == c_DIV_LAST);

  // The bit on the wire is always taken from the end of the buffer that
  // leaves first, so the buffer only ever shifts toward that end.
  generate
    if (LSB_FIRST != 0) begin : g_lsb_first
      assign w_ser_bit   = w_buf_nxt[0];
      assign w_buf_shift = {1'b0, r_buf[c_W-1:1]};
    end else begin : g_msb_first
      assign w_ser_bit   = w_buf_nxt[c_W-1];
      assign w_buf_shift = {r_buf[c_W-2:0], 1'b0};
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= c_S_IDLE;
      r_buf     <= '0;
      r_bit_cnt <= '0;
      r_div_cnt <= '0;
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
      r_ser     <= 1'b0;
      r_srclk   <= 1'b0;
      r_rclk    <= 1'b0;
      r_srclr_n <= 1'b1;
      r_oe_n    <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_buf     <= w_buf_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_div_cnt <= w_div_cnt_nxt;
      r_ready   <= w_ready_nxt;
      r_done    <= w_done_nxt;
      r_ser     <= w_ser_nxt;
      r_srclk   <= w_srclk_nxt;
      r_rclk    <= w_rclk_nxt;
      r_srclr_n <= w_srclr_n_nxt;
      r_oe_n    <= w_oe_n_nxt;
    end
  end

  // Divider restarts at zero on every state change.
  always_comb begin
    w_state_nxt   = r_state;
    w_buf_nxt     = r_buf;
    w_bit_cnt_nxt = r_bit_cnt;
    w_div_cnt_nxt = '0;
    w_done_nxt    = 1'b0;
    w_latched     = 1'b0;
    case (r_state)
      c_S_IDLE: begin
        if (i_Clear) begin
          w_state_nxt = c_S_CLR;
        end else if (i_Enable) begin
          w_state_nxt   = c_S_SHIFT_LO;
          w_buf_nxt     = i_Data;
          w_bit_cnt_nxt = '0;
        end
      end
      c_S_SHIFT_LO: begin
        if (w_div_last) begin
          w_state_nxt = c_S_SHIFT_HI;
        end else begin
          w_div_cnt_nxt = r_div_cnt + 1'b1;
        end
      end
      c_S_SHIFT_HI: begin
        if (w_div_last) begin
          if (r_bit_cnt == c_BIT_LAST) begin
            w_state_nxt = c_S_LATCH;
          end else begin
            w_state_nxt   = c_S_SHIFT_LO;
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
            w_buf_nxt     = w_buf_shift;
          end
        end else begin
          w_div_cnt_nxt = r_div_cnt + 1'b1;
        end
      end
      c_S_LATCH: begin
        if (w_div_last) begin
          w_state_nxt = c_S_IDLE;
          w_done_nxt  = 1'b1;
          w_latched   = 1'b1;
        end else begin
          w_div_cnt_nxt = r_div_cnt + 1'b1;
        end
      end
      c_S_CLR: begin
        if (w_div_last) begin
          w_state_nxt = c_S_CLR_LATCH;
        end else begin
          w_div_cnt_nxt = r_div_cnt + 1'b1;
        end
      end
      c_S_CLR_LATCH: begin
        if (w_div_last) begin
          w_state_nxt = c_S_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_div_cnt_nxt = r_div_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = c_S_IDLE;
      end
    endcase
  end

  // Pin values are decoded from the next state so every output is a flop.
  always_comb begin
    w_ready_nxt   = (w_state_nxt == c_S_IDLE);
    w_ser_nxt     = 1'b0;
    w_srclk_nxt   = 1'b0;
    w_rclk_nxt    = 1'b0;
    w_srclr_n_nxt = 1'b1;
    w_oe_n_nxt    = w_latched ? 1'b0 : r_oe_n;
    case (w_state_nxt)
      c_S_SHIFT_LO: begin
        w_ser_nxt = w_ser_bit;
      end
      c_S_SHIFT_HI: begin
        w_ser_nxt   = w_ser_bit;
        w_srclk_nxt = 1'b1;
      end
      c_S_LATCH: begin
        w_rclk_nxt = 1'b1;
      end
      c_S_CLR: begin
        w_srclr_n_nxt = 1'b0;
      end
      c_S_CLR_LATCH: begin
        w_rclk_nxt = 1'b1;
      end
      default: begin
        w_ser_nxt = 1'b0;
      end
    endcase
  end

  assign o_Ready   = r_ready;
  assign o_Done    = r_done;
  assign o_SER     = r_ser;
  assign o_SRCLK   = r_srclk;
  assign o_RCLK    = r_rclk;
  assign o_SRCLR_n = r_srclr_n;
  assign o_OE_n    = r_oe_n;

endmodule
`default_nettype wire

// File: doc/shift_reg_chain.md
Name: shift_reg_chain

Overview:
Parametrised driver for N daisy-chained 74HC595 shift registers. It is the successor to the single-chip 8-bit ShiftReg: it generalises the word width to 8*N_CHIPS, adds a programmable serial clock divider and selectable bit order, and drives the chip's SRCLR and OE pins. It sits between a control/sequencer block (valid/ready handshake) and the 595 pins.

Parameters:
N_CHIPS, 2, number of chained 74HC595 devices; W = 8*N_CHIPS data bits (N_CHIPS >= 1)
CLK_DIV, 2, i_clk cycles per SRCLK/RCLK/SRCLR half-period or pulse (CLK_DIV >= 1)
LSB_FIRST, 0, 0 = shift i_Data[W-1] first; 1 = shift i_Data[0] first

Ports:
i_clk  in  1  system clock; all logic on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_Data  in  W  parallel word; sampled on accept
i_Enable  in  1  transfer request; accepted when o_Ready=1
i_Clear  in  1  clear request; accepted when o_Ready=1
o_Ready  out  1  idle, can accept a request
o_Done  out  1  one-cycle pulse when a transfer or clear completes
o_SER  out  1  serial data to the first chip's SER
o_SRCLK  out  1  shift clock
o_RCLK  out  1  storage-register latch clock
o_SRCLR_n  out  1  shift-register clear, active low
o_OE_n  out  1  output enable, active low

Behaviour:
- Reset (async assert, sync release): o_Ready=1, o_Done=0, o_SER=0, o_SRCLK=0, o_RCLK=0, o_SRCLR_n=1, o_OE_n=1. Any in-progress transfer is abandoned, and RCLK is not pulsed for it.
- All outputs are registered. No combinational path from inputs to outputs.
- FSM states: IDLE, SHIFT_LO, SHIFT_HI, LATCH, CLR, CLR_LATCH.
- IDLE: o_Ready=1.
  - i_Clear=1 -> CLR. i_Clear has priority when it is high in the same cycle as i_Enable.
  - Otherwise i_Enable=1 -> capture i_Data into the shift buffer, set bit counter to 0, go to SHIFT_LO.
  - o_Ready drops on the cycle after the accept edge.
- SHIFT_LO: o_SRCLK=0 and o_SER = current bit, held for CLK_DIV cycles. Then -> SHIFT_HI.
- SHIFT_HI: o_SRCLK=1 for CLK_DIV cycles, with o_SER unchanged (it stays stable through the rising edge).
  - If bit counter = W-1 -> LATCH.
  - Otherwise increment the counter and -> SHIFT_LO.
- Bit order:
  - LSB_FIRST=0: bit k of the transfer is i_Data[W-1-k]. After the latch, i_Data[W-1] is at QH of the last chip and i_Data[0] is at QA of the first chip.
  - LSB_FIRST=1: bit k is i_Data[k].
- LATCH: o_SRCLK=0, o_RCLK=1 for CLK_DIV cycles.
  - Then o_RCLK=0, o_Done=1 for one cycle, o_Ready=1, -> IDLE.
  - o_OE_n goes to 0 on the first completed LATCH after reset and stays 0 until the next reset. This keeps 595 power-up garbage off the pins.
- Transfer busy time (o_Ready=0) = (2W+1)*CLK_DIV cycles exactly.
- CLR: o_SRCLR_n=0 for CLK_DIV cycles. Then CLR_LATCH: o_SRCLR_n=1, o_RCLK=1 for CLK_DIV cycles. Then o_Done pulse, -> IDLE.
  - Clear busy time = 2*CLK_DIV cycles. o_OE_n is unchanged by a clear.
- While o_Ready=0, i_Enable and i_Clear are ignored: no queueing, and i_Data changes have no effect.
- Back-to-back: i_Enable held high is accepted again in the cycle o_Ready returns to 1.
- o_SER returns to 0 in IDLE. o_SRCLK and o_RCLK are never high simultaneously.
- Counter widths: bit counter $clog2(W) (minimum 1), divider counter $clog2(CLK_DIV) (minimum 1). No wrap beyond terminal counts.

Test Plan:
- N_CHIPS=2, CLK_DIV=2, LSB_FIRST=0, i_Data=16'hA53C, one-cycle i_Enable:
  - SER sampled at the 16 SRCLK rising edges = 1010_0101_0011_1100.
  - o_Ready low for exactly 66 cycles; one RCLK pulse 2 cycles wide.
  - o_Done pulses once; o_OE_n falls after the latch.
- Same transfer with LSB_FIRST=1 -> SER sequence = 0011_1100_1010_0101 (i_Data[0] first).
  - A bench 595 model shows QA..QH of chip0/chip1 matching i_Data.
- CLK_DIV=1, N_CHIPS=1, i_Data=8'hFF, i_Enable held high for 30 cycles:
  - Two transfers back-to-back, each 17 busy cycles, zero idle gap.
  - No third accept starts before cycle 34.
- i_Clear and i_Enable asserted in the same cycle:
  - Clear runs first: SRCLR_n low 2 cycles, RCLK high 2 cycles, o_Done, with no SRCLK edges.
  - o_OE_n stays 1 if no prior transfer has completed.
- i_rst_n driven low mid-transfer (after bit 5), without a clock edge:
  - All outputs go to reset values immediately; no RCLK pulse occurs.
  - A new transfer after release completes normally.
- i_Enable pulses and i_Data changes during busy are ignored; the shifted word equals the value captured at accept.
